// File: rtl/mousetrap_pkg.sv
// Shared sizing for the latch pipeline FIFO: default geometry and occupancy counter width.
package mousetrap_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/latch_stage.sv
// One pipeline slot: full flag plus payload register, loaded on move-in, vacated on move-out.
// Exposes its next full state so the parent can register an exact occupancy count.
module latch_stage
    import mousetrap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             full_nxt,
    output logic [WIDTH-1:0] dout
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end else begin
            full_d = load | (full_q & ~advance);
            if (load) begin
                data_d = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign full_nxt = full_d;
    assign dout     = data_q;

endmodule

// File: rtl/latch_pipeline_fifo.sv
// Bubble-collapsing DEPTH-stage pipeline FIFO, DEPTH-cycle latency, full throughput.
// Backpressure ripples through a combinational ready chain so a full pipe still accepts while draining.
module latch_pipeline_fifo
    import mousetrap_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             extReset,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] OutData,
    input  logic             OutReady,
    input  logic             Flush,
    output logic [OCC_W-1:0] Occupancy
);

    logic [DEPTH-1:0] full_q;
    logic [DEPTH-1:0] full_nxt;
    logic [DEPTH:0]   rdy;
    logic [DEPTH:0]   mv;
    logic [WIDTH-1:0] stage_din [DEPTH];
    logic [WIDTH-1:0] stage_dat [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    // A stage is ready if it is empty or its occupant leaves this cycle; Flush vetoes every move.
    always_comb begin
        rdy[DEPTH] = OutReady;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~full_q[k] | rdy[k+1];
        end
        mv[0] = InValid & rdy[0] & ~Flush;
        for (int k = 1; k < DEPTH; k++) begin
            mv[k] = full_q[k-1] & rdy[k] & ~Flush;
        end
        mv[DEPTH] = full_q[DEPTH-1] & OutReady & ~Flush;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_din[k] = InData;
        end else begin : g_body
            assign stage_din[k] = stage_dat[k-1];
        end

        latch_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (Clk),
            .rst      (extReset),
            .load     (mv[k]),
            .advance  (mv[k+1]),
            .clear    (Flush),
            .din      (stage_din[k]),
            .full     (full_q[k]),
            .full_nxt (full_nxt[k]),
            .dout     (stage_dat[k])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(full_nxt[k]);
        end
    end

    always_ff @(posedge Clk or posedge extReset) begin
        if (extReset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign InReady   = rdy[0] & ~Flush & ~extReset;
    assign OutValid  = full_q[DEPTH-1];
    assign OutData   = stage_dat[DEPTH-1];
    assign Occupancy = occ_q;

endmodule

// File: tb/tb_latch_pipeline_fifo.sv
// Scoreboard bench for latch_pipeline_fifo: directed latency/backpressure/flush/reset cases plus a random soak.
module tb_latch_pipeline_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = 3;

    logic             Clk = 1'b0;
    logic             extReset;
    logic             InValid;
    logic [WIDTH-1:0] InData;
    logic             InReady;
    logic             OutValid;
    logic [WIDTH-1:0] OutData;
    logic             OutReady;
    logic             Flush;
    logic [OCC_W-1:0] Occupancy;

    logic [WIDTH-1:0] sb[$];
    int model_occ = 0;
    int n_out     = 0;
    int n_chk     = 0;
    int n_pass    = 0;

    always #5 Clk = ~Clk;

    latch_pipeline_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clk       (Clk),
        .extReset  (extReset),
        .InValid   (InValid),
        .InData    (InData),
        .InReady   (InReady),
        .OutValid  (OutValid),
        .OutData   (OutData),
        .OutReady  (OutReady),
        .Flush     (Flush),
        .Occupancy (Occupancy)
    );

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        while ((Occupancy != 0 || OutValid) && n < 100) begin
            step();
            n++;
        end
        check(name, Occupancy == 0 && sb.size() == 0 && n < 100, 32'(Occupancy), 0);
    endtask

    // Monitor: samples at the falling edge, i.e. the settled state that the next rising edge will act on.
    initial begin
        logic [WIDTH-1:0] exp;
        forever begin
            @(negedge Clk);
            if (!extReset) begin
                check("occupancy", 32'(Occupancy) == 32'(model_occ), 32'(Occupancy), 32'(model_occ));
                if (InValid && InReady) begin
                    sb.push_back(InData);
                    model_occ++;
                end
                if (OutValid && OutReady && !Flush) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 1'b0, 32'(OutData), 0);
                    end else begin
                        exp = sb.pop_front();
                        check("out_data", OutData == exp, 32'(OutData), 32'(exp));
                    end
                    model_occ--;
                    n_out++;
                end
                if (Flush) begin
                    sb.delete();
                    model_occ = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int sent;
        int cyc;
        logic [7:0] push3 [3];
        extReset = 1'b1;
        InValid  = 1'b0;
        InData   = '0;
        OutReady = 1'b0;
        Flush    = 1'b0;

        // Reset state
        #2;
        check("rst_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        check("rst_occ", Occupancy == 0, 32'(Occupancy), 0);
        check("rst_inready", InReady == 1'b0, 32'(InReady), 0);
        check("rst_outdata", OutData == 8'h00, 32'(OutData), 0);
        repeat (2) @(posedge Clk);
        #3 extReset = 1'b0;
        step();

        // Single token latency
        InValid = 1'b1; InData = 8'hA5; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        check("lat_e0_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        check("lat_e0_occ", Occupancy == 1, 32'(Occupancy), 1);
        step(); step();
        check("lat_e2_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        step();
        check("lat_e3_outvalid", OutValid == 1'b1, 32'(OutValid), 1);
        check("lat_e3_outdata", OutData == 8'hA5, 32'(OutData), 32'hA5);
        check("lat_e3_occ", Occupancy == 1, 32'(Occupancy), 1);
        step();
        check("lat_e4_occ", Occupancy == 0, 32'(Occupancy), 0);
        check("lat_e4_outvalid", OutValid == 1'b0, 32'(OutValid), 0);

        // Fill against backpressure, then pass-through while full
        OutReady = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            InValid = 1'b1;
            InData  = 8'(v);
            @(negedge Clk);
            check($sformatf("fill_rdy_%0d", v), InReady == (v <= 4), 32'(InReady), 32'(v <= 4));
            step();
        end
        check("fill_occ", Occupancy == 4, 32'(Occupancy), 4);
        OutReady = 1'b1;
        @(negedge Clk);
        check("full_passthru_rdy", InReady == 1'b1, 32'(InReady), 1);
        step();
        InValid = 1'b0;
        check("full_passthru_occ", Occupancy == 4, 32'(Occupancy), 4);
        drain("fill_drain");

        // Streaming: one token per cycle, no bubbles
        n0 = n_out;
        OutReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            InValid = 1'b1;
            InData  = 8'(8'h40 + i);
            @(negedge Clk);
            check($sformatf("stream_rdy_%0d", i), InReady == 1'b1, 32'(InReady), 1);
            step();
        end
        InValid = 1'b0;
        step(); step(); step();
        check("stream_out_19", n_out - n0 == 19, 32'(n_out - n0), 19);
        step();
        check("stream_out_20", n_out - n0 == 20, 32'(n_out - n0), 20);
        drain("stream_drain");

        // Flush with a token offered in the same cycle
        push3[0] = 8'h11; push3[1] = 8'h22; push3[2] = 8'h33;
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1;
            InData  = push3[i];
            step();
        end
        check("preflush_occ", Occupancy == 3, 32'(Occupancy), 3);
        InData = 8'h44;
        Flush  = 1'b1;
        @(negedge Clk);
        check("flush_inready", InReady == 1'b0, 32'(InReady), 0);
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        check("flush_occ", Occupancy == 0, 32'(Occupancy), 0);
        check("flush_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        OutReady = 1'b1;
        InValid  = 1'b1;
        InData   = 8'h55;
        step();
        drain("flush_drain");

        // Asynchronous reset between edges with two tokens held
        OutReady = 1'b0;
        InValid = 1'b1; InData = 8'h66; step();
        InValid = 1'b1; InData = 8'h77; step();
        InValid = 1'b0;
        #2 extReset = 1'b1;
        #1;
        check("arst_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        check("arst_occ", Occupancy == 0, 32'(Occupancy), 0);
        check("arst_inready", InReady == 1'b0, 32'(InReady), 0);
        check("arst_outdata", OutData == 8'h00, 32'(OutData), 0);
        sb.delete();
        model_occ = 0;
        extReset = 1'b0;
        step();
        InValid = 1'b1; InData = 8'h3C; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        step(); step();
        check("post_rst_e2_outvalid", OutValid == 1'b0, 32'(OutValid), 0);
        step();
        check("post_rst_e3_outvalid", OutValid == 1'b1, 32'(OutValid), 1);
        check("post_rst_e3_outdata", OutData == 8'h3C, 32'(OutData), 32'h3C);
        drain("rst_drain");

        // Random handshake soak
        n0   = n_out;
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 1));
            InData   = 8'(sent * 7 + 3);
            @(negedge Clk);
            if (InValid && InReady) sent++;
            step();
            cyc++;
        end
        check("rand_sent", sent == 1000, 32'(sent), 1000);
        drain("rand_drain");
        check("rand_delivered", n_out - n0 == 1000, 32'(n_out - n0), 1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/latch_pipeline_fifo.md
LATCH_PIPELINE_FIFO -- requirements
Module: latch_pipeline_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per token (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of storage stages (>=2).
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port extReset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port InValid, input, 1, upstream token present.
REQ-006 SHALL have port InData, input, WIDTH, upstream token payload.
REQ-007 SHALL have port InReady, output, 1, stage 0 can accept this cycle.
REQ-008 SHALL have port OutValid, output, 1, last stage holds a token.
REQ-009 SHALL have port OutData, output, WIDTH, last stage payload.
REQ-010 SHALL have port OutReady, input, 1, downstream accepts this cycle.
REQ-011 SHALL have port Flush, input, 1, synchronous discard of all tokens.
REQ-012 SHALL have port Occupancy, output, OCC_W = clog2(DEPTH+1), tokens held.

Function
REQ-013 SHALL hold per stage k (0..DEPTH-1) a full bit F[k] and a WIDTH-bit data register D[k]; stage DEPTH-1 drives OutValid=F[DEPTH-1], OutData=D[DEPTH-1].
REQ-014 SHALL compute ready chain combinationally: R[DEPTH]=OutReady; R[k] = !F[k] | R[k+1]; InReady = R[0] & !Flush.
REQ-015 SHALL define transfer into stage k as M[k] = V[k-1] & R[k], where V[-1]=InValid and V[k]=F[k] for k>=0; output transfer M[DEPTH] = F[DEPTH-1] & OutReady.
REQ-016 SHALL update F[k] <= M[k] | (F[k] & !M[k+1]) and load D[k] <= D[k-1] (InData for k=0) only when M[k]; D[k] otherwise unchanged.
REQ-017 SHALL give latency DEPTH cycles: token accepted at edge n is presented on OutValid after edge n+DEPTH-1, when all stages ahead are empty.
REQ-018 SHALL sustain throughput of one token per cycle when InValid and OutReady are both held high.
REQ-019 SHALL collapse bubbles: a token advances into any empty stage every cycle regardless of OutReady.
REQ-020 SHALL, when full (all F=1) and OutReady=0, hold InReady=0 and keep all D/F stable.
REQ-021 SHALL, when full and OutReady=1, accept a new token in the same cycle (InReady=1 via ready chain).
REQ-022 SHALL preserve token order and never duplicate or drop a token except via Flush or reset.
REQ-023 SHALL, on Flush=1 at an edge, clear all F to 0, perform no input transfer, and ignore OutReady (no output transfer counted); Flush takes priority over all transfers.
REQ-024 SHALL drive Occupancy as registered popcount of F, equal to number of set F bits after each edge.
REQ-025 SHALL leave OutData at last loaded value while OutValid=0 (don't-care to consumers).

Reset
REQ-026 SHALL, while extReset=1, force all F to 0, all D to 0, Occupancy to 0, OutValid to 0, OutData to 0, asynchronously.
REQ-027 SHALL, on reset asserted mid-transfer, discard all held tokens; first acceptance possible at first rising Clk edge after extReset deasserts.
REQ-028 SHALL report InReady=0 while extReset=1.

Structure
REQ-029 SHALL place OCC_W computation and default WIDTH/DEPTH constants in shared package mousetrap_pkg.
REQ-030 SHALL instantiate DEPTH copies of sub-module latch_stage (one F bit + D register + load/clear logic); ready/move chain in top level.

Verification
REQ-031 SHALL verify: WIDTH=8, DEPTH=4, empty, single InData=0xA5 accepted at edge 0, OutReady=1 -> OutValid=1, OutData=0xA5 after edge 3, Occupancy 1 then 0 after edge 4.
REQ-032 SHALL verify: OutReady=0, push 0x01..0x05 back-to-back -> 0x01..0x04 accepted, InReady=0 on 5th, Occupancy=4; OutReady=1 then outputs 0x01..0x05 in order, 0x05 accepted same cycle first pop occurs.
REQ-033 SHALL verify: InValid=1 and OutReady=1 continuously for 20 tokens -> after fill, one token out per cycle, no bubbles, ordered.
REQ-034 SHALL verify: pipeline holding 3 tokens, Flush=1 with InValid=1 -> Occupancy=0 and OutValid=0 after edge, flushing-cycle input not accepted.
REQ-035 SHALL verify: extReset pulsed asynchronously between edges with 2 tokens held -> OutValid=0, Occupancy=0 immediately; token 0x3C pushed after release emerges DEPTH cycles later.
REQ-036 SHALL verify: random InValid/OutReady (50%) over 1000 tokens -> scoreboard shows in-order, lossless delivery, Occupancy always equals accepted minus delivered.
